// File: rtl/per2axi_pkg.sv
// Shared definitions for the per2axi response path.
//   resp_t       : AXI response code (R/B resp field)
//   RESP_*       : AXI response encodings
package per2axi_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    localparam int unsigned PER_RDATA_WIDTH = 32;

endpackage : per2axi_pkg

// File: rtl/per2axi_res_id_table.sv
// Per-AXI-ID side table for outstanding transactions.
// Each entry holds the address half (add[2]) and a flag marking a pending
// load-type atomic whose B beat must be swallowed.
//   clk_i, rst_i       : clock, async active-high reset
//   trans_we_i/id/half : read issue -> half[id] <= half
//   atop_we_i/id/half  : atomic issue -> half[id] <= half, atop[id] <= 1
//   clr_we_i/clr_id_i  : swallowed B beat -> atop[id] <= 0
//   r_id_i / r_half_c  : async read of half for the R channel ID
//   b_id_i / b_atop_c  : async read of atop flag for the B channel ID
module per2axi_res_id_table #(
    parameter int unsigned ID_WIDTH = 3,
    parameter int unsigned NB_IDS   = 2 ** ID_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                trans_we_i,
    input  logic [ID_WIDTH-1:0] trans_id_i,
    input  logic                trans_half_i,
    input  logic                atop_we_i,
    input  logic [ID_WIDTH-1:0] atop_id_i,
    input  logic                atop_half_i,
    input  logic                clr_we_i,
    input  logic [ID_WIDTH-1:0] clr_id_i,
    input  logic [ID_WIDTH-1:0] r_id_i,
    output logic                r_half_c,
    input  logic [ID_WIDTH-1:0] b_id_i,
    output logic                b_atop_c
);

    logic [NB_IDS-1:0] half_q;
    logic [NB_IDS-1:0] atop_q;

    // Table update; trans and atop never target the same ID in one cycle.
    // A new atomic issue wins over a clear on the same ID.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            half_q <= '0;
            atop_q <= '0;
        end else begin
            if (trans_we_i) begin
                half_q[trans_id_i] <= trans_half_i;
            end
            if (clr_we_i) begin
                atop_q[clr_id_i] <= 1'b0;
            end
            if (atop_we_i) begin
                half_q[atop_id_i] <= atop_half_i;
                atop_q[atop_id_i] <= 1'b1;
            end
        end
    end

    // Lookups see the registered (pre-write) contents.
    assign r_half_c = half_q[r_id_i];
    assign b_atop_c = atop_q[b_id_i];

endmodule : per2axi_res_id_table

// File: rtl/per2axi_res_channel_buf.sv
// Response stage of the per2axi bridge: merges AXI R and B into one registered
// 32-bit peripheral response per transaction, R having priority over B.
//   clk_i, rst_i               : clock, async active-high reset
//   trans_* / atop_*           : issue side-band from the request stage
//   axi_master_r_* / _b_*      : AXI R and B channels
//   per_slave_r_*              : registered response (valid is a 1-cycle pulse)
module per2axi_res_channel_buf
    import per2axi_pkg::*;
#(
    parameter int unsigned PER_ID_WIDTH   = 5,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 6,
    parameter int unsigned AXI_ID_WIDTH   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      trans_req_i,
    input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,

    input  logic                      atop_req_i,
    input  logic [AXI_ID_WIDTH-1:0]   atop_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] atop_add_i,

    input  logic                      axi_master_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
    input  logic [1:0]                axi_master_r_resp_i,
    input  logic                      axi_master_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
    output logic                      axi_master_r_ready_o,

    input  logic                      axi_master_b_valid_i,
    input  logic [1:0]                axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
    output logic                      axi_master_b_ready_o,

    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o
);

    localparam int unsigned NB_IDS = 2 ** AXI_ID_WIDTH;

    if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
        $error("per2axi_res_channel_buf: only AXI_DATA_WIDTH == 64 is supported");
    end

    logic                       r_half_c;
    logic                       b_atop_c;
    logic                       b_accept_c;
    logic                       b_drop_c;

    logic                       sel_valid_c;
    logic                       sel_opc_c;
    logic [AXI_ID_WIDTH-1:0]    sel_id_c;
    logic [31:0]                sel_rdata_c;
    logic [PER_ID_WIDTH-1:0]    sel_onehot_c;

    logic                       valid_q;
    logic                       opc_q;
    logic [PER_ID_WIDTH-1:0]    id_q;
    logic [31:0]                rdata_q;

    logic                       unused_inputs_c;

    // R is always accepted; B only when no R competes.
    assign axi_master_r_ready_o = ~rst_i;
    assign axi_master_b_ready_o = ~rst_i & ~axi_master_r_valid_i;

    assign b_accept_c = axi_master_b_valid_i & ~axi_master_r_valid_i;
    // B of a load-type atomic carries no data for the master: swallow it.
    assign b_drop_c   = b_accept_c & b_atop_c;

    per2axi_res_id_table #(
        .ID_WIDTH (AXI_ID_WIDTH),
        .NB_IDS   (NB_IDS)
    ) i_id_table (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .trans_we_i   (trans_req_i),
        .trans_id_i   (trans_id_i),
        .trans_half_i (trans_add_i[2]),
        .atop_we_i    (atop_req_i),
        .atop_id_i    (atop_id_i),
        .atop_half_i  (atop_add_i[2]),
        .clr_we_i     (b_drop_c),
        .clr_id_i     (axi_master_b_id_i),
        .r_id_i       (axi_master_r_id_i),
        .r_half_c     (r_half_c),
        .b_id_i       (axi_master_b_id_i),
        .b_atop_c     (b_atop_c)
    );

    // Response select: R beat, else a non-swallowed B beat.
    always_comb begin
        sel_valid_c = 1'b0;
        sel_opc_c   = 1'b0;
        sel_id_c    = '0;
        sel_rdata_c = '0;
        if (axi_master_r_valid_i) begin
            sel_valid_c = 1'b1;
            sel_opc_c   = axi_master_r_resp_i[1];
            sel_id_c    = axi_master_r_id_i;
            sel_rdata_c = r_half_c ? axi_master_r_data_i[63:32]
                                   : axi_master_r_data_i[31:0];
        end else if (b_accept_c && !b_atop_c) begin
            sel_valid_c = 1'b1;
            sel_opc_c   = axi_master_b_resp_i[1];
            sel_id_c    = axi_master_b_id_i;
            // Store-conditional result: 0 on exclusive success, 1 otherwise.
            sel_rdata_c = 32'(axi_master_b_resp_i != RESP_EXOKAY);
        end
    end

    // One-hot peripheral ID; AXI IDs beyond the master count map to 0.
    always_comb begin
        sel_onehot_c = '0;
        for (int unsigned i = 0; i < PER_ID_WIDTH; i++) begin
            if (32'(sel_id_c) == i) begin
                sel_onehot_c[i] = 1'b1;
            end
        end
    end

    // Output register; payload holds its last value between pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            opc_q   <= 1'b0;
            id_q    <= '0;
            rdata_q <= '0;
        end else begin
            valid_q <= sel_valid_c;
            if (sel_valid_c) begin
                opc_q   <= sel_opc_c;
                id_q    <= sel_onehot_c;
                rdata_q <= sel_rdata_c;
            end
        end
    end

    assign per_slave_r_valid_o = valid_q;
    assign per_slave_r_opc_o   = opc_q;
    assign per_slave_r_id_o    = id_q;
    assign per_slave_r_rdata_o = rdata_q;

    assign unused_inputs_c = ^{axi_master_r_last_i, axi_master_r_user_i,
                               axi_master_b_user_i, trans_add_i, atop_add_i};

    a_r_id_range : assert property (@(posedge clk_i) disable iff (rst_i)
        axi_master_r_valid_i |-> (32'(axi_master_r_id_i) < PER_ID_WIDTH));

    a_b_id_range : assert property (@(posedge clk_i) disable iff (rst_i)
        b_accept_c |-> (32'(axi_master_b_id_i) < PER_ID_WIDTH));

endmodule : per2axi_res_channel_buf

// File: tb/tb_per2axi_res_channel_buf.sv
module tb_per2axi_res_channel_buf;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        trans_req_i;
    logic [2:0]  trans_id_i;
    logic [31:0] trans_add_i;
    logic        atop_req_i;
    logic [2:0]  atop_id_i;
    logic [31:0] atop_add_i;
    logic        r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [2:0]  r_id;
    logic [5:0]  r_user;
    logic        r_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic [2:0]  b_id;
    logic [5:0]  b_user;
    logic        b_ready;
    logic        o_valid;
    logic        o_opc;
    logic [4:0]  o_id;
    logic [31:0] o_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    per2axi_res_channel_buf dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .trans_req_i          (trans_req_i),
        .trans_id_i           (trans_id_i),
        .trans_add_i          (trans_add_i),
        .atop_req_i           (atop_req_i),
        .atop_id_i            (atop_id_i),
        .atop_add_i           (atop_add_i),
        .axi_master_r_valid_i (r_valid),
        .axi_master_r_data_i  (r_data),
        .axi_master_r_resp_i  (r_resp),
        .axi_master_r_last_i  (r_last),
        .axi_master_r_id_i    (r_id),
        .axi_master_r_user_i  (r_user),
        .axi_master_r_ready_o (r_ready),
        .axi_master_b_valid_i (b_valid),
        .axi_master_b_resp_i  (b_resp),
        .axi_master_b_id_i    (b_id),
        .axi_master_b_user_i  (b_user),
        .axi_master_b_ready_o (b_ready),
        .per_slave_r_valid_o  (o_valid),
        .per_slave_r_opc_o    (o_opc),
        .per_slave_r_id_o     (o_id),
        .per_slave_r_rdata_o  (o_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: per-ID table as plain arrays, expected response per cycle.
    bit          m_half [8];
    bit          m_atop [8];
    logic        e_valid = 1'b0;
    logic        e_opc   = 1'b0;
    logic [4:0]  e_id    = '0;
    logic [31:0] e_rdata = '0;

    always @(posedge clk_i) begin
        logic [4:0] one;
        one = 5'b00001;
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                m_half[i] = 1'b0;
                m_atop[i] = 1'b0;
            end
            e_valid = 1'b0; e_opc = 1'b0; e_id = '0; e_rdata = '0;
        end else begin
            e_valid = 1'b0;
            if (r_valid) begin
                e_valid = 1'b1;
                e_opc   = r_resp[1];
                e_id    = one << r_id;
                e_rdata = m_half[r_id] ? r_data[63:32] : r_data[31:0];
            end else if (b_valid) begin
                if (m_atop[b_id]) begin
                    m_atop[b_id] = 1'b0;
                end else begin
                    e_valid = 1'b1;
                    e_opc   = b_resp[1];
                    e_id    = one << b_id;
                    e_rdata = (b_resp == 2'b01) ? 32'd0 : 32'd1;
                end
            end
            if (trans_req_i) m_half[trans_id_i] = trans_add_i[2];
            if (atop_req_i) begin
                m_half[atop_id_i] = atop_add_i[2];
                m_atop[atop_id_i] = 1'b1;
            end
        end
        #1;
        chk("model_valid", 64'(o_valid), 64'(e_valid));
        chk("model_opc",   64'(o_opc),   64'(e_opc));
        chk("model_id",    64'(o_id),    64'(e_id));
        chk("model_rdata", 64'(o_rdata), 64'(e_rdata));
        if (!rst_i) begin
            chk("model_r_ready", 64'(r_ready), 64'd1);
            chk("model_b_ready", 64'(b_ready), 64'(!r_valid));
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle();
        trans_req_i = 1'b0; atop_req_i = 1'b0; r_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        trans_id_i = '0; trans_add_i = '0; atop_id_i = '0; atop_add_i = '0;
        r_data = '0; r_resp = '0; r_last = 1'b1; r_id = '0; r_user = '0;
        b_resp = '0; b_id = '0; b_user = '0;
        #1;
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_id",    64'(o_id),    64'd0);
        chk("reset_rdata", 64'(o_rdata), 64'd0);
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;

        // 1: read of upper half
        trans_req_i = 1'b1; trans_id_i = 3'd2; trans_add_i = 32'h104;
        cyc();
        idle();
        r_valid = 1'b1; r_id = 3'd2; r_data = 64'hAAAA_BBBB_CCCC_DDDD; r_resp = 2'b00;
        chk("t1_r_ready", 64'(r_ready), 64'd1);
        cyc();
        chk("t1_valid", 64'(o_valid), 64'd1);
        chk("t1_id",    64'(o_id),    64'b00100);
        chk("t1_rdata", 64'(o_rdata), 64'hAAAABBBB);
        chk("t1_opc",   64'(o_opc),   64'd0);
        idle();
        cyc();
        chk("t1_idle_valid", 64'(o_valid), 64'd0);
        chk("t1_hold_rdata", 64'(o_rdata), 64'hAAAABBBB);

        // 2: R and B collide
        r_valid = 1'b1; r_id = 3'd1; r_data = 64'h1111_2222_3333_4444; r_resp = 2'b00;
        b_valid = 1'b1; b_id = 3'd3; b_resp = 2'b00;
        #1 chk("t2_b_ready_low", 64'(b_ready), 64'd0);
        cyc();
        chk("t2_r_first_id",    64'(o_id),    64'b00010);
        chk("t2_r_first_rdata", 64'(o_rdata), 64'h33334444);
        r_valid = 1'b0;
        #1 chk("t2_b_ready_high", 64'(b_ready), 64'd1);
        cyc();
        chk("t2_b_valid", 64'(o_valid), 64'd1);
        chk("t2_b_id",    64'(o_id),    64'b01000);
        chk("t2_b_rdata", 64'(o_rdata), 64'd1);
        idle();

        // 3: load atomic, B before R
        atop_req_i = 1'b1; atop_id_i = 3'd0; atop_add_i = 32'h100;
        cyc();
        idle();
        b_valid = 1'b1; b_id = 3'd0; b_resp = 2'b00;
        cyc();
        chk("t3_b_dropped", 64'(o_valid), 64'd0);
        idle();
        r_valid = 1'b1; r_id = 3'd0; r_data = 64'h0123_4567_0000_0007; r_resp = 2'b00;
        cyc();
        chk("t3_r_valid", 64'(o_valid), 64'd1);
        chk("t3_r_rdata", 64'(o_rdata), 64'd7);
        chk("t3_r_id",    64'(o_id),    64'b00001);
        idle();
        b_valid = 1'b1; b_id = 3'd0; b_resp = 2'b00;
        cyc();
        chk("t3_atop_cleared", 64'(o_valid), 64'd1);
        idle();

        // 4: store-conditional results on id 4
        b_valid = 1'b1; b_id = 3'd4; b_resp = 2'b01;
        cyc();
        chk("t4_exokay_rdata", 64'(o_rdata), 64'd0);
        chk("t4_exokay_id",    64'(o_id),    64'b10000);
        b_resp = 2'b00;
        cyc();
        chk("t4_okay_rdata", 64'(o_rdata), 64'd1);
        b_resp = 2'b10;
        trans_req_i = 1'b1; trans_id_i = 3'd3; trans_add_i = 32'h4;
        cyc();
        chk("t4_slverr_opc", 64'(o_opc), 64'd1);
        idle();

        // 5: async reset with a read outstanding
        rst_i = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(o_valid), 64'd0);
        chk("t5_rst_opc",   64'(o_opc),   64'd0);
        chk("t5_rst_id",    64'(o_id),    64'd0);
        chk("t5_rst_rdata", 64'(o_rdata), 64'd0);
        cyc();
        rst_i = 1'b0;
        r_valid = 1'b1; r_id = 3'd3; r_data = 64'hDEAD_BEEF_0000_0055; r_resp = 2'b00;
        cyc();
        chk("t5_post_rst_rdata", 64'(o_rdata), 64'h55);
        idle();

        // 6: back-to-back reads on ids 0..4
        trans_req_i = 1'b1; trans_id_i = 3'd1; trans_add_i = 32'h4;
        cyc();
        idle();
        for (int k = 0; k < 5; k++) begin
            r_valid = 1'b1; r_id = 3'(k); r_resp = 2'b00;
            r_data = {32'hA0 + 32'(k), 32'hB0 + 32'(k)};
            cyc();
            chk("t6_valid", 64'(o_valid), 64'd1);
            chk("t6_id",    64'(o_id),    64'(5'b1 << k));
            chk("t6_rdata", 64'(o_rdata), (k == 1) ? 64'hA1 : 64'(32'hB0 + 32'(k)));
        end
        idle();
        cyc();

        // Random traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            trans_req_i = ($urandom_range(0, 2) == 0);
            trans_id_i  = 3'($urandom_range(0, 4));
            trans_add_i = $urandom;
            atop_req_i  = ($urandom_range(0, 4) == 0);
            atop_id_i   = 3'($urandom_range(0, 4));
            if (trans_req_i && atop_req_i && atop_id_i == trans_id_i) atop_req_i = 1'b0;
            atop_add_i  = $urandom;
            r_valid     = ($urandom_range(0, 1) == 0);
            r_id        = 3'($urandom_range(0, 4));
            r_data      = {$urandom, $urandom};
            r_resp      = 2'($urandom_range(0, 3));
            r_user      = 6'($urandom);
            b_valid     = ($urandom_range(0, 2) != 0);
            b_id        = 3'($urandom_range(0, 4));
            b_resp      = 2'($urandom_range(0, 3));
            b_user      = 6'($urandom);
            cyc();
        end
        idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_per2axi_res_channel_buf
